// File: rtl/llc_rst_flush_ctrl_pkg.sv
// Shared types and constants for the LLC reset/flush sequencer.
// The widths here are the production LLC geometry. The sequencer itself is
// parameterised, so that it can also be built with a smaller geometry.
package llc_rst_flush_ctrl_pkg;

  localparam int LLC_SET_BITS = 10;
  localparam int LLC_SETS     = 1 << LLC_SET_BITS;
  localparam int LLC_WAYS     = 16;
  localparam int LLC_WAY_BITS = $clog2(LLC_WAYS);

  typedef logic [LLC_SET_BITS-1:0] llc_set_t;
  typedef logic [LLC_WAY_BITS-1:0] llc_way_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST    = 3'd1,
    FL_RD  = 3'd2,
    FL_CAP = 3'd3,
    FL_WB  = 3'd4,
    FL_INV = 3'd5
  } llc_rst_flush_state_t;

endpackage

// File: rtl/llc_rst_flush_ctrl_way_prienc.sv
// Lowest-set-bit encoder over a per-way mask.
// It returns whether any bit is set and the index of the lowest set bit.
// An empty mask yields index 0.
module llc_way_prienc #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  // Scan from the top way down, so that the last hit is the lowest set bit.
  always_comb begin
    o_found = |i_vec;
    o_idx   = {W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      o_idx = i_vec[i] ? W'(i) : o_idx;
    end
  end

endmodule

// File: rtl/llc_rst_flush_ctrl.sv
// LLC reset/flush sequencer.
// It walks every set under control of the register block's set counter.
// Reset sweep: clears each set in one cycle.
// Flush sweep: reads a set, writes back its valid+dirty ways lowest-first,
// then invalidates the set if any of its ways was valid.
module llc_rst_flush_ctrl #(
  parameter int LLC_SET_BITS = 10,
  parameter int LLC_WAYS     = 16,
  parameter int LLC_WAY_BITS = $clog2(LLC_WAYS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_rst_state,
  input  logic                    i_rst_stall,
  input  logic                    i_flush_stall,
  input  logic [LLC_SET_BITS-1:0] i_rst_flush_stalled_set,
  input  logic [LLC_WAYS-1:0]     i_valid_vec,
  input  logic [LLC_WAYS-1:0]     i_dirty_vec,
  input  logic                    i_wb_ready,
  output logic                    o_clr_rst_stall,
  output logic                    o_clr_flush_stall,
  output logic                    o_incr_rst_flush_stalled_set,
  output logic                    o_clr_rst_flush_stalled_set,
  output logic                    o_rd_set_en,
  output logic [LLC_SET_BITS-1:0] o_rd_set,
  output logic                    o_wr_clr_set_en,
  output logic [LLC_SET_BITS-1:0] o_wr_set,
  output logic                    o_wb_valid,
  output logic [LLC_SET_BITS-1:0] o_wb_set,
  output logic [LLC_WAY_BITS-1:0] o_wb_way,
  output logic                    o_rst_done,
  output logic                    o_flush_done,
  output logic                    o_busy
);

  import llc_rst_flush_ctrl_pkg::*;

  llc_rst_flush_state_t    r_state;
  llc_rst_flush_state_t    w_state_nxt;
  logic [LLC_WAYS-1:0]     r_pend_mask;
  logic [LLC_WAYS-1:0]     r_vmask;
  logic [LLC_WAYS-1:0]     w_clr_bit;
  logic                    w_found;
  logic [LLC_WAY_BITS-1:0] w_way;
  logic                    w_last_set;
  logic                    w_wb_fire;

  // The register block owns the set counter, so every array port addresses it.
  assign o_rd_set = i_rst_flush_stalled_set;
  assign o_wr_set = i_rst_flush_stalled_set;
  assign o_wb_set = i_rst_flush_stalled_set;

  assign w_last_set = (i_rst_flush_stalled_set == {LLC_SET_BITS{1'b1}});
  assign w_clr_bit  = {{(LLC_WAYS-1){1'b0}}, 1'b1} << w_way;
  assign w_wb_fire  = (r_state == FL_WB) && w_found && i_wb_ready;

  llc_way_prienc #(
    .N (LLC_WAYS),
    .W (LLC_WAY_BITS)
  ) u_way_prienc (
    .i_vec   (r_pend_mask),
    .o_found (w_found),
    .o_idx   (w_way)
  );

  // State register. A synchronous restart returns the sequencer to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else if (i_rst_state) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Per-set masks.
  // The masks are captured one cycle after the read, which matches the array latency.
  // Each way that the writeback path accepts is removed from the pending mask.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_mask <= {LLC_WAYS{1'b0}};
      r_vmask     <= {LLC_WAYS{1'b0}};
    end else if (i_rst_state) begin
      r_pend_mask <= {LLC_WAYS{1'b0}};
      r_vmask     <= {LLC_WAYS{1'b0}};
    end else if (r_state == FL_CAP) begin
      r_pend_mask <= i_valid_vec & i_dirty_vec;
      r_vmask     <= i_valid_vec;
    end else if (w_wb_fire) begin
      r_pend_mask <= r_pend_mask & ~w_clr_bit;
    end
  end

  // Next-state logic and output decode of the current state and the masks.
  always_comb begin
    w_state_nxt                  = r_state;
    o_clr_rst_stall              = 1'b0;
    o_clr_flush_stall            = 1'b0;
    o_incr_rst_flush_stalled_set = 1'b0;
    o_clr_rst_flush_stalled_set  = 1'b0;
    o_rd_set_en                  = 1'b0;
    o_wr_clr_set_en              = 1'b0;
    o_wb_valid                   = 1'b0;
    o_wb_way                     = {LLC_WAY_BITS{1'b0}};
    o_rst_done                   = 1'b0;
    o_flush_done                 = 1'b0;
    o_busy                       = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (i_rst_stall) begin
          w_state_nxt = RST;
        end else if (i_flush_stall) begin
          w_state_nxt = FL_RD;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RST: begin
        o_wr_clr_set_en = 1'b1;
        if (w_last_set) begin
          o_clr_rst_stall             = 1'b1;
          o_clr_rst_flush_stalled_set = 1'b1;
          o_rst_done                  = 1'b1;
          w_state_nxt                 = IDLE;
        end else begin
          o_incr_rst_flush_stalled_set = 1'b1;
        end
      end
      FL_RD: begin
        o_rd_set_en = 1'b1;
        w_state_nxt = FL_CAP;
      end
      FL_CAP: begin
        w_state_nxt = FL_WB;
      end
      FL_WB: begin
        o_wb_valid = w_found;
        o_wb_way   = w_way;
        if (!w_found) begin
          w_state_nxt = FL_INV;
        end else begin
          w_state_nxt = FL_WB;
        end
      end
      FL_INV: begin
        o_wr_clr_set_en = |r_vmask;
        if (w_last_set) begin
          o_clr_flush_stall           = 1'b1;
          o_clr_rst_flush_stalled_set = 1'b1;
          o_flush_done                = 1'b1;
          w_state_nxt                 = IDLE;
        end else begin
          o_incr_rst_flush_stalled_set = 1'b1;
          w_state_nxt                  = FL_RD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_llc_rst_flush_ctrl.sv
// Bench for llc_rst_flush_ctrl with 4 sets and 4 ways.
// The expected per-cycle output traces are built from the sweep rules as
// per-set / per-way loops. The traces are then replayed against the DUT,
// together with a model of the register block and a model of the tag array.
module tb_llc_rst_flush_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_rst_state, i_rst_stall, i_flush_stall, i_wb_ready;
  logic [1:0] i_set;
  logic [3:0] i_valid_vec, i_dirty_vec;
  logic       o_clr_rst_stall, o_clr_flush_stall, o_incr, o_clr_set;
  logic       o_rd_set_en, o_wr_clr_set_en, o_wb_valid, o_rst_done, o_flush_done, o_busy;
  logic [1:0] o_rd_set, o_wr_set, o_wb_set, o_wb_way;

  typedef struct packed {
    logic        rdy;
    logic        srst;
    logic [17:0] exp;
  } ent_t;

  ent_t       q[$];
  int         n_vec = 0;
  int         n_err = 0;
  string      cur_tag;
  logic       reg_rst = 1'b0, reg_fl = 1'b0;
  logic [1:0] reg_set = 2'd0;
  logic [3:0] valid_arr [4];
  logic [3:0] dirty_arr [4];
  logic [3:0] nxt_valid = 4'd0, nxt_dirty = 4'd0;

  always #5 clk = ~clk;

  llc_rst_flush_ctrl #(.LLC_SET_BITS(2), .LLC_WAYS(4)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .i_rst_state                  (i_rst_state),
    .i_rst_stall                  (i_rst_stall),
    .i_flush_stall                (i_flush_stall),
    .i_rst_flush_stalled_set      (i_set),
    .i_valid_vec                  (i_valid_vec),
    .i_dirty_vec                  (i_dirty_vec),
    .i_wb_ready                   (i_wb_ready),
    .o_clr_rst_stall              (o_clr_rst_stall),
    .o_clr_flush_stall            (o_clr_flush_stall),
    .o_incr_rst_flush_stalled_set (o_incr),
    .o_clr_rst_flush_stalled_set  (o_clr_set),
    .o_rd_set_en                  (o_rd_set_en),
    .o_rd_set                     (o_rd_set),
    .o_wr_clr_set_en              (o_wr_clr_set_en),
    .o_wr_set                     (o_wr_set),
    .o_wb_valid                   (o_wb_valid),
    .o_wb_set                     (o_wb_set),
    .o_wb_way                     (o_wb_way),
    .o_rst_done                   (o_rst_done),
    .o_flush_done                 (o_flush_done),
    .o_busy                       (o_busy)
  );

  // Expected output word. The set field is repeated for rd_set, wr_set and wb_set.
  function automatic logic [17:0] pk(input logic clrr, input logic clrf, input logic incr,
                                     input logic clrs, input logic rd, input logic wr,
                                     input logic wbv, input logic [1:0] way, input logic rdone,
                                     input logic fdone, input logic busy, input logic [1:0] s);
    return {clrr, clrf, incr, clrs, rd, wr, wbv, way, rdone, fdone, busy, s, s, s};
  endfunction

  function automatic void pe(input logic rdy, input logic srst, input logic [17:0] exp);
    q.push_back('{rdy, srst, exp});
  endfunction

  function automatic void add_idle(input logic [1:0] s);
    pe(1'($urandom), 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, s));
  endfunction

  // Reset sweep: one clear per set; the last set completes instead of advancing.
  function automatic void add_rst_sweep();
    for (int s = 0; s < 4; s++) begin
      pe(1'($urandom), 1'b0, pk(s == 3, 1'b0, s != 3, s == 3, 1'b0, 1'b1, 1'b0, 2'd0,
                               s == 3, 1'b0, 1'b1, 2'(s)));
    end
  endfunction

  // Flush sweep.
  // Per set: read, capture, one writeback per valid+dirty way (lowest first,
  // each preceded by its stall cycles), one empty-mask cycle, then invalidate.
  // A first_stall of -1 means the first writeback gets a random stall count too.
  function automatic void add_flush(input int max_stall, input int first_stall);
    logic [3:0] pend;
    int         k;
    bit         first;
    for (int s = 0; s < 4; s++) begin
      pend  = valid_arr[s] & dirty_arr[s];
      first = 1'b1;
      pe(1'($urandom), 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'(s)));
      pe(1'($urandom), 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'(s)));
      for (int w = 0; w < 4; w++) begin
        if (pend[w]) begin
          k = (first && first_stall >= 0) ? first_stall : int'($urandom_range(max_stall, 0));
          first = 1'b0;
          for (int j = 0; j < k; j++) begin
            pe(1'b0, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'(w), 1'b0, 1'b0, 1'b1, 2'(s)));
          end
          pe(1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'(w), 1'b0, 1'b0, 1'b1, 2'(s)));
        end
      end
      pe(1'($urandom), 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'(s)));
      pe(1'($urandom), 1'b0, pk(1'b0, s == 3, s != 3, s == 3, 1'b0, |valid_arr[s], 1'b0, 2'd0,
                               1'b0, s == 3, 1'b1, 2'(s)));
    end
  endfunction

  // One clock cycle.
  // Drive the inputs, check the outputs at the falling edge, then advance the
  // register-block and tag-array models on the rising edge.
  task automatic cycle(input ent_t e, input int step);
    logic [17:0] obs;
    logic        rd, incr, clrs, clrr, clrf;
    logic [1:0]  rd_s;
    i_wb_ready    = e.rdy;
    i_rst_state   = e.srst;
    i_valid_vec   = nxt_valid;
    i_dirty_vec   = nxt_dirty;
    i_rst_stall   = reg_rst;
    i_flush_stall = reg_fl;
    i_set         = reg_set;
    @(negedge clk);
    obs = {o_clr_rst_stall, o_clr_flush_stall, o_incr, o_clr_set, o_rd_set_en, o_wr_clr_set_en,
           o_wb_valid, o_wb_way, o_rst_done, o_flush_done, o_busy, o_rd_set, o_wr_set, o_wb_set};
    n_vec++;
    assert (obs === e.exp) else begin
      n_err++;
      $error("FAIL %s step %0d: observed %h, expected %h", cur_tag, step, obs, e.exp);
    end
    rd   = o_rd_set_en;
    incr = o_incr;
    clrs = o_clr_set;
    clrr = o_clr_rst_stall;
    clrf = o_clr_flush_stall;
    rd_s = reg_set;
    @(posedge clk);
    #1;
    if (e.srst) begin
      reg_rst = 1'b0;
      reg_fl  = 1'b0;
      reg_set = 2'd0;
    end else begin
      if (clrs) reg_set = 2'd0;
      else if (incr) reg_set = reg_set + 2'd1;
      if (clrr) reg_rst = 1'b0;
      if (clrf) reg_fl = 1'b0;
    end
    if (rd) begin
      nxt_valid = valid_arr[rd_s];
      nxt_dirty = dirty_arr[rd_s];
    end else begin
      nxt_valid = 4'($urandom);
      nxt_dirty = 4'($urandom);
    end
  endtask

  task automatic run(input string tag);
    int step;
    cur_tag = tag;
    step    = 0;
    while (q.size() > 0) begin
      cycle(q.pop_front(), step);
      step++;
    end
  endtask

  function automatic void fill_clean();
    for (int s = 0; s < 4; s++) begin
      valid_arr[s] = 4'b0101;
      dirty_arr[s] = 4'b0000;
    end
  endfunction

  initial begin
    rst = 1'b0;
    i_rst_state = 1'b0;
    fill_clean();

    // Reset state with a reset sweep already requested, then release.
    reg_rst = 1'b1;
    add_idle(2'd0);
    add_idle(2'd0);
    run("reset_state");
    rst = 1'b1;
    add_idle(2'd0);
    add_rst_sweep();
    add_idle(2'd0);
    run("rst_sweep");

    // Clean flush: 4 cycles per set, no writebacks.
    reg_fl = 1'b1;
    add_idle(2'd0);
    add_flush(0, -1);
    add_idle(2'd0);
    run("flush_clean");

    // Dirty ways 1 and 3 in set 1, always ready.
    valid_arr[1] = 4'b1111;
    dirty_arr[1] = 4'b1010;
    reg_fl = 1'b1;
    add_idle(2'd0);
    add_flush(0, -1);
    add_idle(2'd0);
    run("flush_dirty");

    // Backpressure: 5 stall cycles on the first writeback.
    reg_fl = 1'b1;
    add_idle(2'd0);
    add_flush(0, 5);
    add_idle(2'd0);
    run("backpressure");

    // Reset and flush requested together: reset first, flush right after rst_done.
    fill_clean();
    dirty_arr[2] = 4'b0100;
    reg_rst = 1'b1;
    reg_fl  = 1'b1;
    add_idle(2'd0);
    add_rst_sweep();
    add_idle(2'd0);
    add_flush(0, -1);
    add_idle(2'd0);
    run("priority");

    // Randomised flushes with random stalls; one set is always fully invalid.
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < 4; s++) begin
        valid_arr[s] = 4'($urandom);
        dirty_arr[s] = 4'($urandom);
      end
      valid_arr[$urandom_range(3, 0)] = 4'b0000;
      reg_fl = 1'b1;
      add_idle(2'd0);
      add_flush(3, -1);
      add_idle(2'd0);
      run("flush_random");
    end

    // Restart while a writeback is pending in set 1, then a fresh reset sweep.
    fill_clean();
    valid_arr[0] = 4'b0001;
    valid_arr[1] = 4'b1111;
    dirty_arr[1] = 4'b0110;
    reg_fl = 1'b1;
    add_idle(2'd0);
    pe(1'($urandom), 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0));
    pe(1'($urandom), 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0));
    pe(1'($urandom), 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0));
    pe(1'($urandom), 1'b0, pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0));
    pe(1'($urandom), 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1));
    pe(1'($urandom), 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1));
    pe(1'b0, 1'b1, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 2'd1));
    add_idle(2'd0);
    add_idle(2'd0);
    run("restart");
    reg_rst = 1'b1;
    add_idle(2'd0);
    add_rst_sweep();
    add_idle(2'd0);
    run("restart_rst_sweep");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/llc_rst_flush_ctrl.md
Name: llc_rst_flush_ctrl

Overview:
- Sequencer that walks every LLC set during reset and flush.
- Reset: clears every set. Flush: writes back valid+dirty ways, then invalidates the set.
- Sits beside the LLC register block. Consumes its rst_stall, flush_stall and rst_flush_stalled_set; drives its clr_rst_stall, clr_flush_stall, incr_rst_flush_stalled_set and clr_rst_flush_stalled_set strobes.
- Drives the tag/state array and the writeback path to the memory-request stage.

Parameters:
LLC_SET_BITS, 10, set index width; sets = 2^LLC_SET_BITS
LLC_WAYS, 16, ways per set (power of two)
LLC_WAY_BITS, $clog2(LLC_WAYS), way index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
rst_state  in  1  synchronous restart: FSM to IDLE, masks cleared
rst_stall  in  1  reset sweep requested (register block)
flush_stall  in  1  flush sweep requested (register block)
rst_flush_stalled_set  in  LLC_SET_BITS  current sweep set (register block)
valid_vec  in  LLC_WAYS  per-way valid of the set read last cycle
dirty_vec  in  LLC_WAYS  per-way dirty of the set read last cycle
wb_ready  in  1  writeback path accepts
clr_rst_stall  out  1  pulse, reset sweep complete
clr_flush_stall  out  1  pulse, flush sweep complete
incr_rst_flush_stalled_set  out  1  pulse, advance set
clr_rst_flush_stalled_set  out  1  pulse, zero set
rd_set_en  out  1  read tag/state of rd_set
rd_set  out  LLC_SET_BITS  set to read
wr_clr_set_en  out  1  invalidate all ways of wr_set (state/dirty/sharers to 0)
wr_set  out  LLC_SET_BITS  set to clear
wb_valid  out  1  writeback request
wb_set  out  LLC_SET_BITS  writeback set
wb_way  out  LLC_WAY_BITS  writeback way
rst_done  out  1  pulse, same cycle as clr_rst_stall
flush_done  out  1  pulse, same cycle as clr_flush_stall
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst=0): state IDLE, all outputs 0, pend_mask=0, vmask=0. rst_state has identical effect, synchronous.
- Registered state; all outputs are combinational decodes of state plus registered masks.
- rd_set, wr_set and wb_set always equal rst_flush_stalled_set.

States and transitions:
- IDLE: if rst_stall, go to RST. Else if flush_stall, go to FL_RD. rst_stall has priority over flush_stall.
- RST: every cycle assert wr_clr_set_en.
  - If set != 2^LLC_SET_BITS-1: assert incr_rst_flush_stalled_set.
  - Else: assert clr_rst_stall, clr_rst_flush_stalled_set and rst_done, then go to IDLE. No incr on the last set.
  - Sweep takes exactly 2^LLC_SET_BITS cycles in RST.
- FL_RD: assert rd_set_en for one cycle, then go to FL_CAP.
- FL_CAP: pend_mask <= valid_vec & dirty_vec; vmask <= valid_vec; go to FL_WB. Array read latency is 1 cycle.
- FL_WB:
  - wb_valid = (pend_mask != 0); wb_way = lowest set bit of pend_mask.
  - On wb_valid & wb_ready, clear that bit.
  - wb_valid stays high and wb_way stays stable until accepted.
  - When pend_mask == 0, go to FL_INV. An empty mask passes through in 1 cycle.
- FL_INV:
  - wr_clr_set_en = (vmask != 0); a set with no valid ways is not written.
  - If set is last: assert clr_flush_stall, clr_rst_flush_stalled_set and flush_done, then go to IDLE.
  - Else: assert incr_rst_flush_stalled_set, go to FL_RD.

Boundary conditions:
- rst_stall rising during a flush is ignored until IDLE. The register block restarts via rst_state.
- flush_stall asserted at the end of a reset sweep is taken the cycle after returning to IDLE.
- Per-set flush cycles = 4 + number of accepted writebacks + wb_ready stall cycles.
- Never assert incr and clr strobes in the same cycle.

Decomposition:
- llc package: llc_set_t, llc_way_t, LLC_SETS, LLC_WAYS, and the llc_rst_flush_state_t enum (IDLE, RST, FL_RD, FL_CAP, FL_WB, FL_INV).
- One sub-module: llc_way_prienc. Parameterised lowest-set-bit encoder giving {found, way index}; used for wb_way.

Test Plan:
(All scenarios use LLC_SET_BITS=2, LLC_WAYS=4, with a bench model of the register block's set counter.)
- Reset sweep: release rst with rst_stall=1 -> wr_clr_set_en 4 consecutive cycles on sets 0,1,2,3; incr on sets 0-2 only; on set 3, clr_rst_stall, clr_rst_flush_stalled_set and rst_done together; then busy=0.
- Flush, clean cache: valid_vec=4'b0101, dirty_vec=0 in all sets -> no wb_valid; wr_clr_set_en once per set; flush_done after 16 cycles.
- Flush with dirty ways: set 1 has valid=4'b1111, dirty=4'b1010, wb_ready=1 -> wb_way 1 then 3 on consecutive cycles with wb_set=1, then wr_clr_set_en on set 1.
- Backpressure: wb_ready=0 for 5 cycles on the first writeback -> wb_valid and wb_way=1 held stable for 5 cycles; no duplicate or skipped way.
- Priority: rst_stall and flush_stall rise in the same cycle -> full reset sweep first; flush starts at set 0 the cycle after rst_done.
- Mid-operation restart: rst_state pulsed while in FL_WB with wb_valid=1 -> next cycle IDLE, wb_valid=0, masks 0; a fresh rst_stall restarts the sweep at set 0.
